// File: rtl/hsynth_rate_switch_seq.sv
// -----------------------------------------------------------------------------
// hsynth_rate_switch_seq
//
// Glitch-safe audio sample-rate change sequencer. A rate-change request mutes
// the DAC path, holds it muted while the audio pipeline drains, programs the
// clock-control block (cmd_reg1 at 0x00, cmd_reg2 at 0x04) over an APB master
// port, waits for the regenerated LRCLK to settle and then unmutes.
//
// Optional build macro:
//   READBACK_VERIFY_EN - after the two writes, read both registers back and
//                        flag err on any mismatch (sequence still completes).
//                        Undefined: writes only; pwrite=1 whenever psel=1.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   rate-change request handshake
//   req_rate[2:0]         0=48k 1=96k 2=44.1k 3=88.2k, 4-7 invalid
//   req_master            1 = codec is clock master, 0 = slave
//   done                  one-cycle pulse at the end of a sequence
//   err                   sticky error, cleared by the next accepted request
//   busy                  high from accept until done
//   mute                  DAC path mute (muted out of reset)
//   lrclk_in              playback LRCLK, asynchronous to clk
//   paddr/psel/penable/pwrite/pwdata/prdata/pready   APB master port
// -----------------------------------------------------------------------------
module hsynth_rate_switch_seq #(
   parameter int unsigned MUTE_CYCLES    = 256,
   parameter int unsigned SETTLE_EDGES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_rate,
   input  logic        req_master,
   output logic        done,
   output logic        err,
   output logic        busy,
   output logic        mute,
   input  logic        lrclk_in,
   output logic [4:0]  paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready
);

   // Counter widths: mute and timeout counters run 0..N-1, edge counter 0..N.
   localparam int MW = (MUTE_CYCLES > 1)    ? $clog2(MUTE_CYCLES)    : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int EW = $clog2(SETTLE_EDGES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUTE,
      S_WR1,
      S_WR2,
`ifdef READBACK_VERIFY_EN
      S_RD1,
      S_RD2,
`endif
      S_SETTLE,
      S_UNMUTE
   } state_t;

   state_t         state;
   state_t         state_nxt;
   logic [1:0]     rate_q;
   logic           master_q;
   logic [MW-1:0]  mute_cnt;
   logic [EW-1:0]  edge_cnt;
   logic [TW-1:0]  to_cnt;
   logic           apb_acc;
   logic           lr_s1;
   logic           lr_s2;
   logic           lr_s3;
   logic           accept;
   logic           lr_rise;
   logic           settle_ok;
   logic           timeout;
   logic           xfer_done;

   // cmd_reg1 = {mclk_div, bclk_div, 14'b0, clk_sel, master}
   function automatic logic [31:0] cmd1_of(input logic [1:0] rate, input logic master);
      logic [31:0] v;
      case (rate)
         2'd0:    v = 32'h0003_0000;
         2'd1:    v = 32'h0001_0000;
         2'd2:    v = 32'h0005_0002;
         default: v = 32'h0002_0002;
      endcase
      return v | {31'b0, master};
   endfunction

   // cmd_reg2 = {16'b0, lr1_div, lr2_div}
   function automatic logic [31:0] cmd2_of(input logic [1:0] rate);
      logic [31:0] v;
      case (rate)
         2'd0:    v = 32'h0000_0F0F;
         2'd1:    v = 32'h0000_0707;
         2'd2:    v = 32'h0000_1717;
         default: v = 32'h0000_0B0B;
      endcase
      return v;
   endfunction

   function automatic logic is_write(input state_t s);
      return (s == S_WR1) || (s == S_WR2);
   endfunction

`ifdef READBACK_VERIFY_EN
   function automatic logic is_bus(input state_t s);
      return (s == S_WR1) || (s == S_WR2) || (s == S_RD1) || (s == S_RD2);
   endfunction

   function automatic logic [4:0] addr_of(input state_t s);
      return ((s == S_WR2) || (s == S_RD2)) ? 5'h04 : 5'h00;
   endfunction
`else
   function automatic logic is_bus(input state_t s);
      return (s == S_WR1) || (s == S_WR2);
   endfunction

   function automatic logic [4:0] addr_of(input state_t s);
      return (s == S_WR2) ? 5'h04 : 5'h00;
   endfunction

   // Read data is only consulted when readback verification is built in.
   logic unused_prdata;
   assign unused_prdata = ^prdata;
`endif

   assign accept    = req_valid & req_ready;
   assign lr_rise   = lr_s2 & ~lr_s3;
   assign settle_ok = (edge_cnt == EW'(SETTLE_EDGES));
   assign timeout   = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
   // apb_acc marks the access phase; the transfer ends when pready is sampled there.
   assign xfer_done = is_bus(state) & apb_acc & pready;

   // LRCLK synchroniser (s1, s2) plus one delay stage for rising-edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         lr_s1 <= 1'b0;
         lr_s2 <= 1'b0;
         lr_s3 <= 1'b0;
      end else begin
         lr_s1 <= lrclk_in;
         lr_s2 <= lr_s1;
         lr_s3 <= lr_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (accept && !req_rate[2]) state_nxt = S_MUTE;
         S_MUTE:   if (mute_cnt == MW'(MUTE_CYCLES - 1)) state_nxt = S_WR1;
         S_WR1:    if (xfer_done) state_nxt = S_WR2;
`ifdef READBACK_VERIFY_EN
         S_WR2:    if (xfer_done) state_nxt = S_RD1;
         S_RD1:    if (xfer_done) state_nxt = S_RD2;
         S_RD2:    if (xfer_done) state_nxt = S_SETTLE;
`else
         S_WR2:    if (xfer_done) state_nxt = S_SETTLE;
`endif
         // A settled LRCLK wins over a timeout landing in the same cycle.
         S_SETTLE: if (settle_ok || timeout) state_nxt = S_UNMUTE;
         S_UNMUTE: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mute      <= 1'b1;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         apb_acc   <= 1'b0;
         rate_q    <= '0;
         master_q  <= 1'b0;
         mute_cnt  <= '0;
         edge_cnt  <= '0;
         to_cnt    <= '0;
      end else begin
         done <= 1'b0;

         if (accept) begin
            rate_q   <= req_rate[1:0];
            master_q <= req_master;
            err      <= req_rate[2];
            if (req_rate[2]) begin
               // Invalid rate: report and stay idle; mute and bus untouched.
               done <= 1'b1;
            end else begin
               busy      <= 1'b1;
               req_ready <= 1'b0;
               mute      <= 1'b1;
            end
         end

         if (state == S_MUTE) mute_cnt <= mute_cnt + MW'(1);
         else                 mute_cnt <= '0;

         // Both SETTLE counters restart from zero on every SETTLE entry.
         if (state == S_SETTLE) begin
            to_cnt <= to_cnt + TW'(1);
            if (lr_rise && !settle_ok) edge_cnt <= edge_cnt + EW'(1);
         end else begin
            to_cnt   <= '0;
            edge_cnt <= '0;
         end

         // Entering a bus state always starts with a setup cycle, so WR1->WR2
         // goes straight from the completing access into the next setup.
         if (is_bus(state_nxt) && (state_nxt != state)) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            apb_acc <= 1'b0;
            pwrite  <= is_write(state_nxt);
            paddr   <= addr_of(state_nxt);
            if (is_write(state_nxt))
               pwdata <= (state_nxt == S_WR1) ? cmd1_of(rate_q, master_q) : cmd2_of(rate_q);
         end else if (is_bus(state) && !apb_acc) begin
            penable <= 1'b1;
            apb_acc <= 1'b1;
         end else if (xfer_done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            apb_acc <= 1'b0;
         end

`ifdef READBACK_VERIFY_EN
         if (xfer_done && (state == S_RD1) && (prdata != cmd1_of(rate_q, master_q))) err <= 1'b1;
         if (xfer_done && (state == S_RD2) && (prdata != cmd2_of(rate_q)))           err <= 1'b1;
`endif

         if ((state == S_SETTLE) && (state_nxt == S_UNMUTE)) begin
            mute <= 1'b0;
            done <= 1'b1;
            if (!settle_ok) err <= 1'b1;
         end

         if (state == S_UNMUTE) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hsynth_rate_switch_seq.sv
// Testbench for hsynth_rate_switch_seq: directed scenarios plus randomized
// requests; a driver pushes expected APB transfers and done events into
// queues, an independent monitor pops and compares them as the DUT acts.
module tb_hsynth_rate_switch_seq;

   localparam int MUTE_CYCLES    = 256;
   localparam int SETTLE_EDGES   = 4;
   localparam int TIMEOUT_CYCLES = 65535;
   localparam int CLK_PERIOD     = 10;
   localparam int LR_HALF        = 37;
   // Four LRCLK rising edges span at least three LRCLK periods.
   localparam int SETTLE_LO      = ((SETTLE_EDGES - 1) * 2 * LR_HALF) / CLK_PERIOD;
   localparam int SETTLE_HI      = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [2:0]  req_rate = 3'd0;
   logic        req_master = 1'b0;
   logic        lrclk_in = 1'b0;
   logic [31:0] prdata = 32'h0;
   logic        pready = 1'b0;
   logic        req_ready, done, err, busy, mute, psel, penable, pwrite;
   logic [4:0]  paddr;
   logic [31:0] pwdata;

   hsynth_rate_switch_seq #(
      .MUTE_CYCLES(MUTE_CYCLES),
      .SETTLE_EDGES(SETTLE_EDGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rate(req_rate), .req_master(req_master),
      .done(done), .err(err), .busy(busy), .mute(mute),
      .lrclk_in(lrclk_in),
      .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .prdata(prdata), .pready(pready)
   );

   always #(CLK_PERIOD / 2) clk = ~clk;

   bit lr_run = 1'b1;
   initial forever begin
      #(LR_HALF);
      lrclk_in = lr_run ? ~lrclk_in : 1'b0;
   end

   // APB slave: pready rises after pready_wait extra access cycles.
   int pready_wait = 0;
   int acc_cnt = 0;
   always @(posedge clk) begin
      #1;
      if (psel && penable) begin
         acc_cnt++;
         pready = (acc_cnt > pready_wait);
      end else begin
         acc_cnt = 0;
         pready = 1'b0;
      end
   end

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          nacc;
   } apb_exp_t;

   typedef struct {
      logic err;
      logic mute;
      int   lo;
      int   hi;
      bit   from_accept;
   } done_exp_t;

   apb_exp_t  apb_q[$];
   done_exp_t done_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   bit model_mute = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_checks++;
      n_fail++;
      $display("FAIL %s: %s", name, what);
   endtask

   // Reference rate tables.
   function automatic logic [31:0] ref_cmd1(input int rate, input bit m);
      logic [31:0] base [4];
      logic [31:0] v;
      base = '{32'h0003_0000, 32'h0001_0000, 32'h0005_0000, 32'h0002_0000};
      v = base[rate];
      if (rate == 2 || rate == 3) v = v | 32'h2;   // 44.1k family
      if (m) v = v | 32'h1;
      return v;
   endfunction

   function automatic logic [31:0] ref_cmd2(input int rate);
      logic [7:0] div [4];
      div = '{8'h0F, 8'h07, 8'h17, 8'h0B};
      return {16'h0000, div[rate], div[rate]};
   endfunction

   // Monitor: samples on the falling edge.
   int cyc = 0;
   int accept_cyc = 0;
   int xfer_cyc = 0;
   int acc = 0;
   bit saw_setup = 1'b0;
   bit unstable = 1'b0;
   bit first_setup = 1'b0;
   logic [4:0]  s_addr = 5'h0;
   logic [31:0] s_data = 32'h0;

   always @(negedge clk) begin
      apb_exp_t  ea;
      done_exp_t ed;
      cyc++;
      if (reset) begin
         saw_setup   = 1'b0;
         first_setup = 1'b0;
         acc         = 0;
      end else begin
         if (req_valid && req_ready) begin
            accept_cyc  = cyc;
            first_setup = (req_rate < 3'd4);
         end
         if (psel && !penable) begin
            s_addr    = paddr;
            s_data    = pwdata;
            saw_setup = 1'b1;
            unstable  = 1'b0;
            acc       = 0;
            if (first_setup) begin
               check_range("mute_hold_cycles", cyc - accept_cyc, MUTE_CYCLES, MUTE_CYCLES + 2);
               first_setup = 1'b0;
            end
         end else if (psel && penable) begin
            acc++;
            if (paddr !== s_addr || pwdata !== s_data) unstable = 1'b1;
            if (pready) begin
               if (apb_q.size() == 0) begin
                  fail_now("apb_unexpected", $sformatf("addr 0x%0h data 0x%0h", paddr, pwdata));
               end else begin
                  ea = apb_q.pop_front();
                  check("apb_addr", 32'(paddr), 32'(ea.addr));
                  check("apb_data", pwdata, ea.data);
                  check("apb_write", 32'(pwrite), 32'd1);
                  check("apb_setup_seen", 32'(saw_setup), 32'd1);
                  check("apb_access_cycles", 32'(acc), 32'(ea.nacc));
                  check("apb_stable", 32'(unstable), 32'd0);
                  check("apb_mute", 32'(mute), 32'd1);
               end
               saw_setup = 1'b0;
               xfer_cyc  = cyc;
            end
         end
         if (done) begin
            if (done_q.size() == 0) begin
               fail_now("done_unexpected", $sformatf("err %0b mute %0b", err, mute));
            end else begin
               ed = done_q.pop_front();
               check("done_err", 32'(err), 32'(ed.err));
               check("done_mute", 32'(mute), 32'(ed.mute));
               check_range("done_latency", cyc - (ed.from_accept ? accept_cyc : xfer_cyc), ed.lo, ed.hi);
            end
         end
      end
   end

   task automatic wait_done(input bit valid_req, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      if (!done) begin
         fail_now("done_timeout", $sformatf("no done within %0d cycles", budget));
         return;
      end
      if (valid_req) check("busy_at_done", 32'(busy), 32'd1);
      @(negedge clk);
      check("done_pulse_width", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
      check("ready_after_done", 32'(req_ready), 32'd1);
   endtask

   task automatic issue(input logic [2:0] rate, input bit m, input int waitn,
                        input bit lr_ok, input bit do_wait);
      apb_exp_t  ea;
      done_exp_t ed;
      int guard;
      guard = 0;
      while (!req_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         fail_now("ready_timeout", "req_ready never returned");
         return;
      end
      pready_wait = waitn;
      lr_run      = lr_ok;
      if (rate < 3'd4) begin
         ea.addr = 5'h00; ea.data = ref_cmd1(int'(rate), m); ea.nacc = waitn + 1;
         apb_q.push_back(ea);
         ea.addr = 5'h04; ea.data = ref_cmd2(int'(rate));    ea.nacc = waitn + 1;
         apb_q.push_back(ea);
         ed.err  = ~lr_ok;
         ed.mute = 1'b0;
         ed.lo   = lr_ok ? SETTLE_LO : TIMEOUT_CYCLES;
         ed.hi   = lr_ok ? SETTLE_HI : TIMEOUT_CYCLES + 3;
         ed.from_accept = 1'b0;
         done_q.push_back(ed);
         model_mute = 1'b0;
      end else begin
         ed.err  = 1'b1;
         ed.mute = model_mute;
         ed.lo   = 1;
         ed.hi   = 1;
         ed.from_accept = 1'b1;
         done_q.push_back(ed);
      end
      @(posedge clk); #1;
      req_valid  = 1'b1;
      req_rate   = rate;
      req_master = m;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_rate   = 3'($urandom);
      req_master = 1'($urandom);
      if (do_wait) wait_done(rate < 3'd4, lr_ok ? 2000 : TIMEOUT_CYCLES + 2000);
   endtask

   initial begin
      #(1_500_000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mute", 32'(mute), 32'd1);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_psel", 32'(psel), 32'd0);
      check("rst_penable", 32'(penable), 32'd0);
      check("rst_pwrite", 32'(pwrite), 32'd0);
      check("rst_paddr", 32'(paddr), 32'd0);
      check("rst_pwdata", pwdata, 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Invalid rate while still muted from reset: mute must stay 1.
      issue(3'd6, 1'b0, 0, 1'b1, 1'b1);
      // 48k master, zero wait states.
      issue(3'd0, 1'b1, 0, 1'b1, 1'b1);
      // 44.1k master, three access cycles per transfer.
      issue(3'd2, 1'b1, 2, 1'b1, 1'b1);
      // Invalid rate after a good config: mute stays 0, err set then cleared below.
      issue(3'd5, 1'b0, 0, 1'b1, 1'b1);
      // 96k slave: err from the previous request must be cleared.
      issue(3'd1, 1'b0, 1, 1'b1, 1'b1);
      // 88.2k with LRCLK stuck low: SETTLE timeout.
      issue(3'd3, 1'b1, 0, 1'b0, 1'b1);

      // Reset during the setup phase of the second write.
      issue(3'd1, 1'b1, 0, 1'b1, 1'b0);
      guard = 0;
      do begin
         @(negedge clk);
         guard++;
      end while (!(psel && !penable && paddr == 5'h04) && guard < 1000);
      if (!(psel && !penable && paddr == 5'h04)) begin
         fail_now("wr2_setup_timeout", "second write setup never seen");
      end
      reset = 1'b1;
      @(negedge clk);
      check("midrst_psel", 32'(psel), 32'd0);
      check("midrst_penable", 32'(penable), 32'd0);
      check("midrst_mute", 32'(mute), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_done", 32'(done), 32'd0);
      reset = 1'b0;
      apb_q.delete();
      done_q.delete();
      model_mute = 1'b1;
      issue(3'd0, 1'b0, 0, 1'b1, 1'b1);

      // Randomized requests, including invalid rates.
      for (int i = 0; i < 12; i++) begin
         issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'b1, 1'b1);
      end

      repeat (5) @(negedge clk);
      check("apb_queue_drained", 32'(apb_q.size()), 32'd0);
      check("done_queue_drained", 32'(done_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
